// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for a shared 8:1 single-bit mux: grants one requester at a
// time for at most QUANTUM cycles, drives the mux select and registers the mux output.
module mux8_rr_scheduler #(
  parameter int unsigned QUANTUM = 4,
  parameter int unsigned CW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       out,
  output logic       out_vld
);

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    gnt_d;
  logic [SW-1:0]   sel_d;
  logic            busy_d;
  logic            out_d;
  logic            load;
  logic            found;
  logic [SW-1:0]   cand;
  logic [SW-1:0]   pick_idx;

  // Rotating scan starting after the last grantee; the current holder is checked last.
  always_comb begin
    found    = 1'b0;
    cand     = '0;
    pick_idx = last_q;
    for (int k = 1; k <= int'(N); k++) begin
      cand = last_q + SW'(k);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt;
    sel_d   = sel;
    busy_d  = busy;
    load    = 1'b0;
    out_d   = busy ? d[sel] : 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) load = 1'b1;
      end
      GRANT: begin
        if (!req[sel] || (cnt_q == '0)) begin
          if (|req) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (load) begin
      state_d = GRANT;
      gnt_d   = N'(1) << pick_idx;
      sel_d   = pick_idx;
      busy_d  = 1'b1;
      last_d  = pick_idx;
      cnt_d   = CW'(QUANTUM - 1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SW'(N - 1);
      cnt_q   <= '0;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      out     <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      busy    <= busy_d;
      out     <= out_d;
      out_vld <= busy;
    end
  end

endmodule
